// File: rtl/fpga_spram_pkg.sv
// Shared types and helpers for the byte-write SRAM model with init sweep.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fpga_spram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of byte lanes in a word of width w.
    function automatic int bytes(input int w);
        return w / 8;
    endfunction

    // Legal geometry: whole bytes per word, at least one word, and the word
    // count fits in the address space.
    function automatic bit params_ok(input int dw, input int aw, input longint depth);
        return (dw > 0) && ((dw % 8) == 0) && (depth >= 1) &&
               (depth <= (longint'(1) << aw));
    endfunction

endpackage

// File: rtl/fpga_spram_lane.sv
// One 8-bit byte lane: read-first array with a synchronous read register.
// Latency: read data valid one edge after re; write lands on the same edge.
// Backpressure: none; accepts one access per cycle, out-of-range reads give 0.
//
// Ports: clk/rst (async active-high, clears only the read register),
//        re (capture read), we (write), hit (address is inside the array),
//        addr, din (write byte), dout (registered read byte).
module fpga_spram_lane #(
    parameter int ADDRWIDTH = 17,
    parameter int MEMDEPTH  = 2**ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 re,
    input  logic                 we,
    input  logic                 hit,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout
);

    localparam int IW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;

    logic [7:0]    mem [0:MEMDEPTH-1];
    logic [IW-1:0] idx;

    assign idx = addr[IW-1:0];

    // Contents are deliberately not reset so a reset never disturbs stored data.
    always_ff @(posedge clk) begin
        if (we && hit) begin
            mem[idx] <= din;
        end
    end

    // Non-blocking read of mem gives the pre-write word on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (re) begin
            dout <= hit ? mem[idx] : 8'h00;
        end
    end

endmodule

// File: rtl/fpga_spram_bw_init.sv
// Single-port SRAM with active-low byte write enables and a post-reset fill sweep.
// Latency: read-first data on Q 1 edge after acceptance (2 with OUTREG=1).
// Backpressure: READY low during the sweep; accesses then are ignored, no stall queue.
//
// Ports: CLK, RST (async active-high), A (word address), CEN (active-low enable),
//        D (write data), BWEN (active-low per-byte write enable), Q (read data),
//        QVLD (Q carries a completed read), READY (user accesses accepted).
module fpga_spram_bw_init
    import fpga_spram_pkg::*;
#(
    parameter int                 DATAWIDTH = 32,
    parameter int                 ADDRWIDTH = 17,
    parameter int                 MEMDEPTH  = 2**ADDRWIDTH,
    parameter int                 OUTREG    = 0,
    parameter int                 INIT_EN   = 1,
    parameter logic [DATAWIDTH-1:0] INITVAL = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ADDRWIDTH-1:0]   A,
    input  logic                   CEN,
    input  logic [DATAWIDTH-1:0]   D,
    input  logic [DATAWIDTH/8-1:0] BWEN,
    output logic [DATAWIDTH-1:0]   Q,
    output logic                   QVLD,
    output logic                   READY
);

    localparam int                 NB    = bytes(DATAWIDTH);
    localparam logic [ADDRWIDTH-1:0] LAST  = ADDRWIDTH'(MEMDEPTH - 1);
    localparam logic [ADDRWIDTH:0]   DEPTH = (ADDRWIDTH + 1)'(MEMDEPTH);

    if (!params_ok(DATAWIDTH, ADDRWIDTH, MEMDEPTH)) begin : g_bad_params
        $error("fpga_spram_bw_init: DATAWIDTH must be a byte multiple and MEMDEPTH must fit ADDRWIDTH");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic                   init_we;
    logic [ADDRWIDTH-1:0]   cnt;
    logic                   acc;
    logic [ADDRWIDTH-1:0]   mem_addr;
    logic [DATAWIDTH-1:0]   mem_din;
    logic                   mem_hit;
    logic [DATAWIDTH-1:0]   rd_dat;
    logic                   rd_vld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Without a sweep, ST_INIT lasts only until the first edge after reset.
    always_comb begin
        state_nxt = state;
        init_we   = 1'b0;
        case (state)
            ST_INIT: begin
                if (INIT_EN != 0) begin
                    init_we = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (init_we) begin
            cnt <= cnt + ADDRWIDTH'(1);
        end
    end

    assign READY = (state == ST_RUN);
    assign acc   = READY & ~CEN;

    // Sweep owns the array while it runs; user inputs are don't-care then.
    assign mem_addr = init_we ? cnt : A;
    assign mem_din  = init_we ? INITVAL : D;
    assign mem_hit  = init_we | ({1'b0, A} < DEPTH);

    for (genvar i = 0; i < NB; i++) begin : g_lane
        fpga_spram_lane #(
            .ADDRWIDTH (ADDRWIDTH),
            .MEMDEPTH  (MEMDEPTH)
        ) u_lane (
            .clk  (CLK),
            .rst  (RST),
            .re   (acc),
            .we   (init_we | (acc & ~BWEN[i])),
            .hit  (mem_hit),
            .addr (mem_addr),
            .din  (mem_din[8*i +: 8]),
            .dout (rd_dat[8*i +: 8])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= acc;
        end
    end

    if (OUTREG != 0) begin : g_outreg
        logic [DATAWIDTH-1:0] q_r;
        logic                 vld_r;

        // Load only on a valid first stage so Q holds between reads.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                q_r   <= '0;
                vld_r <= 1'b0;
            end else begin
                vld_r <= rd_vld;
                if (rd_vld) begin
                    q_r <= rd_dat;
                end
            end
        end

        assign Q    = q_r;
        assign QVLD = vld_r;
    end else begin : g_direct
        assign Q    = rd_dat;
        assign QVLD = rd_vld;
    end

endmodule

// File: tb/tb_fpga_spram_bw_init.sv
module tb_fpga_spram_bw_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // u1: 32-bit, 16 words, sweep to A5A5A5A5, latency 1
    logic        r1 = 1'b1, cen1 = 1'b1, v1, rdy1;
    logic [3:0]  a1 = '0, bw1 = 4'hF;
    logic [31:0] d1 = '0, q1;
    // u2: 64-bit, 16 words, output register, latency 2
    logic        r2 = 1'b1, cen2 = 1'b1, v2, rdy2;
    logic [3:0]  a2 = '0;
    logic [7:0]  bw2 = 8'hFF;
    logic [63:0] d2 = '0, q2;
    // u3: 32-bit, 12 words in a 16-word address space
    logic        r3 = 1'b1, cen3 = 1'b1, v3, rdy3;
    logic [3:0]  a3 = '0, bw3 = 4'hF;
    logic [31:0] d3 = '0, q3;
    // u4: 32-bit, no sweep
    logic        r4 = 1'b1, cen4 = 1'b1, v4, rdy4;
    logic [3:0]  a4 = '0, bw4 = 4'hF;
    logic [31:0] d4 = '0, q4;

    localparam logic [31:0] IV1 = 32'hA5A5A5A5;
    localparam logic [63:0] IV2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [31:0] IV3 = 32'h0BAD_F00D;

    fpga_spram_bw_init #(.DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(16), .OUTREG(0),
                         .INIT_EN(1), .INITVAL(IV1))
    u1 (.CLK(clk), .RST(r1), .A(a1), .CEN(cen1), .D(d1), .BWEN(bw1),
        .Q(q1), .QVLD(v1), .READY(rdy1));

    fpga_spram_bw_init #(.DATAWIDTH(64), .ADDRWIDTH(4), .MEMDEPTH(16), .OUTREG(1),
                         .INIT_EN(1), .INITVAL(IV2))
    u2 (.CLK(clk), .RST(r2), .A(a2), .CEN(cen2), .D(d2), .BWEN(bw2),
        .Q(q2), .QVLD(v2), .READY(rdy2));

    fpga_spram_bw_init #(.DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(12), .OUTREG(0),
                         .INIT_EN(1), .INITVAL(IV3))
    u3 (.CLK(clk), .RST(r3), .A(a3), .CEN(cen3), .D(d3), .BWEN(bw3),
        .Q(q3), .QVLD(v3), .READY(rdy3));

    fpga_spram_bw_init #(.DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(16), .OUTREG(0),
                         .INIT_EN(0), .INITVAL(32'h0))
    u4 (.CLK(clk), .RST(r4), .A(a4), .CEN(cen4), .D(d4), .BWEN(bw4),
        .Q(q4), .QVLD(v4), .READY(rdy4));

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++; if (q1 !== 32'h0)   begin fails++; $display("FAIL reset_q1 got %h exp 0", q1); end
        tests++; if (v1 !== 1'b0)    begin fails++; $display("FAIL reset_qvld1 got %b exp 0", v1); end
        tests++; if (rdy1 !== 1'b0)  begin fails++; $display("FAIL reset_ready1 got %b exp 0", rdy1); end
        tests++; if (q2 !== 64'h0)   begin fails++; $display("FAIL reset_q2 got %h exp 0", q2); end
        tests++; if (v2 !== 1'b0)    begin fails++; $display("FAIL reset_qvld2 got %b exp 0", v2); end
        tests++; if (rdy2 !== 1'b0)  begin fails++; $display("FAIL reset_ready2 got %b exp 0", rdy2); end
        tests++; if (q3 !== 32'h0)   begin fails++; $display("FAIL reset_q3 got %h exp 0", q3); end
        tests++; if (rdy3 !== 1'b0)  begin fails++; $display("FAIL reset_ready3 got %b exp 0", rdy3); end
        tests++; if (q4 !== 32'h0)   begin fails++; $display("FAIL reset_q4 got %h exp 0", q4); end
        tests++; if (rdy4 !== 1'b0)  begin fails++; $display("FAIL reset_ready4 got %b exp 0", rdy4); end
    endtask

    task automatic test_init_fill();
        r1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tests++;
            if (rdy1 !== (k >= 16)) begin
                fails++; $display("FAIL init_ready edge %0d got %b exp %b", k, rdy1, (k >= 16));
            end
        end
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i); cen1 = 1'b0;
            @(negedge clk);
            tests++;
            if (v1 !== 1'b1 || q1 !== IV1) begin
                fails++; $display("FAIL init_read a=%0d got q=%h v=%b exp q=%h v=1", i, q1, v1, IV1);
            end
        end
        cen1 = 1'b1;
        @(negedge clk);
        tests++; if (v1 !== 1'b0) begin fails++; $display("FAIL idle_qvld got %b exp 0", v1); end
        tests++; if (q1 !== IV1)  begin fails++; $display("FAIL idle_qhold got %h exp %h", q1, IV1); end
    endtask

    task automatic test_byte_lane();
        a1 = 4'd3; d1 = 32'h11223344; bw1 = 4'b1010; cen1 = 1'b0;
        @(negedge clk);
        tests++;
        if (v1 !== 1'b1 || q1 !== IV1) begin
            fails++; $display("FAIL bw_readfirst got q=%h v=%b exp q=%h v=1", q1, v1, IV1);
        end
        bw1 = 4'hF;
        @(negedge clk);
        tests++;
        if (v1 !== 1'b1 || q1 !== 32'hA522A544) begin
            fails++; $display("FAIL bw_readback got q=%h v=%b exp q=a522a544 v=1", q1, v1);
        end
        cen1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_init();
        r1 = 1'b1;
        @(negedge clk);
        r1 = 1'b0;
        // user traffic during the sweep must be ignored
        a1 = 4'd3; d1 = 32'h0; bw1 = 4'h0; cen1 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            tests++; if (v1 !== 1'b0) begin fails++; $display("FAIL init1_qvld cyc %0d got %b exp 0", k, v1); end
        end
        r1 = 1'b1;
        #1;
        tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL midinit_ready got %b exp 0", rdy1); end
        @(negedge clk);
        r1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tests++;
            if (rdy1 !== (k == 16) || v1 !== 1'b0) begin
                fails++; $display("FAIL reinit edge %0d got ready=%b v=%b exp ready=%b v=0", k, rdy1, v1, (k == 16));
            end
        end
        bw1 = 4'hF;
        @(negedge clk);
        tests++;
        if (v1 !== 1'b1 || q1 !== IV1) begin
            fails++; $display("FAIL reinit_read a=3 got q=%h v=%b exp q=%h v=1", q1, v1, IV1);
        end
        cen1 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [3];
        logic [63:0] eq;
        bit ok;
        vals[0] = 64'h1111_2222_3333_4444;
        vals[1] = 64'h5555_6666_7777_8888;
        vals[2] = 64'h9999_AAAA_BBBB_CCCC;
        r2 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rdy2 === 1'b1) ok = 1'b1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL b2b_ready_timeout got 0 exp 1"); end
        for (int i = 0; i < 3; i++) begin
            a2 = 4'(i); d2 = vals[i]; bw2 = 8'h00; cen2 = 1'b0;
            @(negedge clk);
        end
        cen2 = 1'b1; bw2 = 8'hFF;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin a2 = 4'(c); cen2 = 1'b0; end
            else cen2 = 1'b1;
            @(negedge clk);
            eq = (c == 0) ? IV2 : vals[(c > 3) ? 2 : c - 1];
            tests++;
            if (v2 !== (c >= 1 && c <= 3) || q2 !== eq) begin
                fails++; $display("FAIL b2b cyc %0d got q=%h v=%b exp q=%h v=%b", c, q2, v2, eq, (c >= 1 && c <= 3));
            end
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        r3 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rdy3 === 1'b1) ok = 1'b1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL oor_ready_timeout got 0 exp 1"); end
        a3 = 4'd13; d3 = 32'hFFFFFFFF; bw3 = 4'h0; cen3 = 1'b0;
        @(negedge clk);
        tests++; if (v3 !== 1'b1 || q3 !== 32'h0) begin fails++; $display("FAIL oor_write got q=%h v=%b exp q=0 v=1", q3, v3); end
        bw3 = 4'hF;
        @(negedge clk);
        tests++; if (v3 !== 1'b1 || q3 !== 32'h0) begin fails++; $display("FAIL oor_read13 got q=%h v=%b exp q=0 v=1", q3, v3); end
        a3 = 4'd12;
        @(negedge clk);
        tests++; if (v3 !== 1'b1 || q3 !== 32'h0) begin fails++; $display("FAIL oor_read12 got q=%h v=%b exp q=0 v=1", q3, v3); end
        a3 = 4'd11;
        @(negedge clk);
        tests++; if (v3 !== 1'b1 || q3 !== IV3) begin fails++; $display("FAIL oor_read11 got q=%h v=%b exp q=%h v=1", q3, v3, IV3); end
        cen3 = 1'b1;
        @(negedge clk);
        tests++; if (v3 !== 1'b0 || q3 !== IV3) begin fails++; $display("FAIL oor_idle got q=%h v=%b exp q=%h v=0", q3, v3, IV3); end
    endtask

    task automatic test_no_init();
        r4 = 1'b0;
        @(negedge clk);
        tests++; if (rdy4 !== 1'b1) begin fails++; $display("FAIL noinit_ready got %b exp 1", rdy4); end
        a4 = 4'd5; d4 = 32'hDEADBEEF; bw4 = 4'h0; cen4 = 1'b0;
        @(negedge clk);
        tests++; if (v4 !== 1'b1) begin fails++; $display("FAIL noinit_wr_qvld got %b exp 1", v4); end
        cen4 = 1'b1; bw4 = 4'hF;
        r4 = 1'b1;
        #1;
        tests++;
        if (v4 !== 1'b0 || q4 !== 32'h0 || rdy4 !== 1'b0) begin
            fails++; $display("FAIL async_flush got q=%h v=%b ready=%b exp q=0 v=0 ready=0", q4, v4, rdy4);
        end
        @(negedge clk);
        r4 = 1'b0;
        @(negedge clk);
        tests++; if (rdy4 !== 1'b1) begin fails++; $display("FAIL noinit_ready2 got %b exp 1", rdy4); end
        a4 = 4'd5; cen4 = 1'b0;
        @(negedge clk);
        tests++;
        if (v4 !== 1'b1 || q4 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL noinit_retain got q=%h v=%b exp q=deadbeef v=1", q4, v4);
        end
        cen4 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_byte_lane();
        test_reset_mid_init();
        test_back_to_back();
        test_out_of_range();
        test_no_init();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
